// File: rtl/tc_pkg.sv
// Shared types and constants for the timer/counter peripheral.
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Word offsets inside the device window
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  // MODE encodings; 2 and 3 behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Window bases of the two instances
  localparam logic [31:0] TC0_BASE = 32'h0000_7f00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7f10;

endpackage

// File: rtl/timer_counter_dev_if.sv
// Bridge-side bus of the timer/counter: select, word offset, data, irq.
interface timer_counter_dev_if;
  logic        sel;
  logic        we;
  logic [3:2]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output sel, we, addr, wdata, input rdata, irq);
  modport slave  (input sel, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/tc_count_fsm.sv
// Count-down FSM: owns state, COUNT and the pending flag.
// Optional feature macro: TC_IRQ_EN (pending flop exists only when defined).
module tc_count_fsm
  import tc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [31:0] preset,
  input  logic        ctrl_wr,
  output logic        en_clr,
  output logic [31:0] count,
  output logic        pending
);

  tc_state_e   state, state_next;
  logic [31:0] count_next;
  logic        pend_set, pend_clr;

  // State and COUNT registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next state, COUNT update, EN-clear request and pending set/clear
  always_comb begin
    state_next = state;
    count_next = count;
    en_clr     = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    case (state)
      ST_IDLE: if (en) state_next = ST_LOAD;
      ST_LOAD: begin
        count_next = preset;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (count != '0) begin
          count_next = count - 32'd1;
        end else begin
          state_next = ST_INT;
          pend_set   = 1'b1;
        end
      end
      ST_INT: begin
        if (mode == MODE_RELOAD) begin
          state_next = ST_LOAD;
          pend_clr   = 1'b1;
        end else begin
          en_clr     = 1'b1;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

`ifdef TC_IRQ_EN
  logic pending_q;

  // Pending flag: set on reaching zero, cleared by a CTRL write or on reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
    end else if (pend_set) begin
      pending_q <= 1'b1;
    end else if (ctrl_wr || pend_clr) begin
      pending_q <= 1'b0;
    end
  end

  assign pending = pending_q;
`else
  logic unused_pend;
  assign unused_pend = ^{ctrl_wr, pend_set, pend_clr};
  assign pending     = 1'b0;
`endif

endmodule

// File: rtl/timer_counter_dev.sv
// Memory-mapped count-down timer: register file, bus decode, rdata mux.
// Optional feature macro: TC_IRQ_EN (CTRL.IM storage and registered irq).
module timer_counter_dev
  import tc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TC0_BASE
)(
  input  logic               clk,
  input  logic               reset,
  timer_counter_dev_if.slave bus
);

  // Decode uses only the word offset; the base is kept for documentation
  localparam logic [31:0] unused_base = BASE_ADDR;

  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pending;
  logic        en_clr;
  logic        ctrl_wr, preset_wr;
  logic [31:0] ctrl_rd;

  assign ctrl_wr   = bus.sel && bus.we && (bus.addr == OFF_CTRL);
  assign preset_wr = bus.sel && bus.we && (bus.addr == OFF_PRESET);

  // CTRL.EN/MODE and PRESET; a CPU write to CTRL overrides the FSM's EN clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      preset    <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en   <= bus.wdata[CTRL_EN];
        ctrl_mode <= bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO];
      end else if (en_clr) begin
        ctrl_en <= 1'b0;
      end
      if (preset_wr) preset <= bus.wdata;
    end
  end

`ifdef TC_IRQ_EN
  logic irq_q;

  // CTRL.IM storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ctrl_im <= 1'b0;
    else if (ctrl_wr) ctrl_im <= bus.wdata[CTRL_IM];
  end

  // Registered interrupt request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= pending & ctrl_im;
  end

  assign bus.irq = irq_q;
`else
  logic unused_pending;
  assign unused_pending = pending;
  assign ctrl_im        = 1'b0;
  assign bus.irq        = 1'b0;
`endif

  tc_count_fsm u_fsm (
    .clk     (clk),
    .reset   (reset),
    .en      (ctrl_en),
    .mode    (ctrl_mode),
    .preset  (preset),
    .ctrl_wr (ctrl_wr),
    .en_clr  (en_clr),
    .count   (count),
    .pending (pending)
  );

  // CTRL read view and offset-based read mux
  always_comb begin
    ctrl_rd                            = '0;
    ctrl_rd[CTRL_EN]                   = ctrl_en;
    ctrl_rd[CTRL_MODE_HI:CTRL_MODE_LO] = ctrl_mode;
    ctrl_rd[CTRL_IM]                   = ctrl_im;
    case (bus.addr)
      OFF_CTRL:   bus.rdata = ctrl_rd;
      OFF_PRESET: bus.rdata = preset;
      OFF_COUNT:  bus.rdata = count;
      default:    bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter_dev.sv
// Directed scoreboard bench for timer_counter_dev.
module tb_timer_counter_dev;
  import tc_pkg::*;

`ifdef TC_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic        irq;
    string       name;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  timer_counter_dev_if bus ();

  timer_counter_dev #(.BASE_ADDR(TC0_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [31:0] ctrlx(input logic [31:0] v);
    return v & (IRQ_ON ? 32'hF : 32'h7);
  endfunction

  task automatic idle(input int unsigned n);
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] d,
                    input logic irq, input string name);
    exp_t e;
    e.d    = d;
    e.irq  = irq & IRQ_ON;
    e.name = name;
    sb.push_back(e);
    bus.sel = 1'b1;
    bus.we  = 1'b0;
    bus.addr = a;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every read cycle consumes one scoreboard entry
  always @(negedge clk) begin
    if (bus.sel === 1'b1 && bus.we === 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: rdata=%h with empty scoreboard", bus.rdata);
      end else begin
        mon_e = sb.pop_front();
        n_cmp++;
        if (bus.rdata !== mon_e.d) begin
          n_bad++;
          $display("FAIL %s rdata: got %h want %h", mon_e.name, bus.rdata, mon_e.d);
        end
        n_cmp++;
        if (bus.irq !== mon_e.irq) begin
          n_bad++;
          $display("FAIL %s irq: got %b want %b", mon_e.name, bus.irq, mon_e.irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, pending=%0d", sb.size());
    $fatal(1);
  end

  initial begin
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = '0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    // Reset state, all offsets
    rd(OFF_CTRL,   32'h0, 1'b0, "rst_ctrl");
    rd(OFF_PRESET, 32'h0, 1'b0, "rst_preset");
    rd(OFF_COUNT,  32'h0, 1'b0, "rst_count");
    rd(2'd3,       32'h0, 1'b0, "rst_off3");
    reset = 1'b1;
    rd(OFF_CTRL,   32'h0, 1'b0, "post_rst_ctrl");

    // Reset mid-count in MODE 1
    wr(OFF_PRESET, 32'd10);
    wr(OFF_CTRL, 32'h3);                   // N
    idle(5);                               // N+1..N+5
    rd(OFF_COUNT, 32'd7, 1'b0, "t1_count7"); // N+6
    reset = 1'b0;
    rd(OFF_CTRL,   32'h0, 1'b0, "t1_rst_ctrl");
    rd(OFF_PRESET, 32'h0, 1'b0, "t1_rst_preset");
    rd(OFF_COUNT,  32'h0, 1'b0, "t1_rst_count");
    rd(2'd3,       32'h0, 1'b0, "t1_rst_off3");
    reset = 1'b1;
    idle(4);
    rd(OFF_COUNT, 32'h0, 1'b0, "t1_no_resume_count");
    rd(OFF_CTRL,  32'h0, 1'b0, "t1_no_resume_ctrl");

    // One-shot, PRESET=3
    wr(OFF_PRESET, 32'd3);
    wr(OFF_CTRL, 32'h9);                   // N
    rd(OFF_CTRL, ctrlx(32'h9), 1'b0, "t2_ctrl_n1");
    idle(1);                               // N+2
    rd(OFF_COUNT, 32'd3, 1'b0, "t2_count3");
    rd(OFF_COUNT, 32'd2, 1'b0, "t2_count2");
    rd(OFF_COUNT, 32'd1, 1'b0, "t2_count1");
    rd(OFF_COUNT, 32'd0, 1'b0, "t2_count0");
    rd(OFF_CTRL, ctrlx(32'h9), 1'b0, "t2_ctrl_int");     // N+7
    rd(OFF_CTRL, ctrlx(32'h8), 1'b1, "t2_ctrl_en_clr");  // N+8
    rd(OFF_COUNT, 32'd0, 1'b1, "t2_irq_held");           // N+9
    wr(OFF_CTRL, 32'h0);                                 // K
    rd(OFF_CTRL, 32'h0, 1'b1, "t2_irq_k1");
    rd(OFF_CTRL, 32'h0, 1'b0, "t2_irq_drop");

    // Auto-reload, PRESET=2: irq pulses at N+7, N+12, N+17
    wr(OFF_PRESET, 32'd2);
    wr(OFF_CTRL, 32'hB);                   // N
    for (int i = 1; i <= 18; i++) begin
      rd(OFF_CTRL, ctrlx(32'hB), (i == 7 || i == 12 || i == 17), $sformatf("t3_c%0d", i));
    end
    wr(OFF_CTRL, 32'h0);
    idle(3);

    // PRESET=0 one-shot
    wr(OFF_PRESET, 32'd0);
    wr(OFF_CTRL, 32'h9);                   // N
    idle(2);
    rd(OFF_COUNT, 32'd0, 1'b0, "t4_cnt");           // N+3
    rd(OFF_COUNT, 32'd0, 1'b0, "t4_int");           // N+4
    rd(OFF_CTRL, ctrlx(32'h8), 1'b1, "t4_irq");     // N+5
    rd(OFF_COUNT, 32'd0, 1'b1, "t4_count_stays0");  // N+6
    wr(OFF_CTRL, 32'h0);
    idle(2);

    // Ignored writes during CNT, PRESET change applies at next reload
    wr(OFF_PRESET, 32'd4);
    wr(OFF_CTRL, 32'hB);                   // N
    idle(2);
    wr(OFF_COUNT, 32'hFFFF);               // N+3
    wr(2'd3, 32'h1234);                    // N+4
    wr(OFF_PRESET, 32'd9);                 // N+5
    rd(OFF_COUNT, 32'd1, 1'b0, "t5_count1");        // N+6
    rd(OFF_COUNT, 32'd0, 1'b0, "t5_count0");        // N+7
    rd(2'd3, 32'd0, 1'b0, "t5_off3");               // N+8
    rd(OFF_PRESET, 32'd9, 1'b1, "t5_preset9");      // N+9
    rd(OFF_COUNT, 32'd9, 1'b0, "t5_reload9");       // N+10
    wr(OFF_CTRL, 32'h0);
    idle(3);

    // CPU CTRL write during INT wins over EN clear
    wr(OFF_PRESET, 32'd1);
    wr(OFF_CTRL, 32'h9);                   // N
    idle(4);
    wr(OFF_CTRL, 32'h9);                   // N+5 (INT)
    rd(OFF_CTRL, ctrlx(32'h9), 1'b1, "t6_en_kept");  // N+6
    rd(OFF_COUNT, 32'd0, 1'b0, "t6_load");           // N+7
    rd(OFF_COUNT, 32'd1, 1'b0, "t6_restart1");       // N+8
    rd(OFF_COUNT, 32'd0, 1'b0, "t6_restart0");       // N+9
    rd(OFF_COUNT, 32'd0, 1'b0, "t6_int2");           // N+10
    rd(OFF_CTRL, ctrlx(32'h8), 1'b1, "t6_irq2");     // N+11
    wr(OFF_CTRL, 32'h0);
    idle(3);

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
